// File: rtl/wb_port_arbiter_pkg.sv
// rtl/wb_port_arbiter_pkg.sv - shared types and constants for the write-back port arbiter
package wb_port_arbiter_pkg;

  // Datapath defaults shared with the register-file write port
  localparam int WB_DATA_W = 64;
  localparam int WB_RD_W   = 5;

  // Write-back mux select encoding
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Which port currently holds the burst
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - request ports and register-file write port bundle
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int RD_W   = WB_RD_W
);

  logic              a_valid;
  logic              a_ready;
  logic [DATA_W-1:0] a_data;
  logic [RD_W-1:0]   a_rd;

  logic              b_valid;
  logic              b_ready;
  logic [DATA_W-1:0] b_data;
  logic [RD_W-1:0]   b_rd;

  logic              out_valid;
  logic              out_ready;
  logic              out_sel;
  logic [DATA_W-1:0] out_data;
  logic [RD_W-1:0]   out_rd;

  // Requesters plus register file: drive requests and consume the held write
  modport master (
    output a_valid, a_data, a_rd,
    output b_valid, b_data, b_rd,
    output out_ready,
    input  a_ready, b_ready,
    input  out_valid, out_sel, out_data, out_rd
  );

  // Arbiter side
  modport slave (
    input  a_valid, a_data, a_rd,
    input  b_valid, b_data, b_rd,
    input  out_ready,
    output a_ready, b_ready,
    output out_valid, out_sel, out_data, out_rd
  );

endinterface

// File: rtl/wb_port_arbiter_pick.sv
// rtl/wb_port_arbiter_pick.sv - combinational burst-limited round-robin winner selection
module wbarb_pick
  import wb_port_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  owner_t           owner,
  input  logic [CNT_W-1:0] cnt,
  input  logic             last_winner,
  input  logic             a_valid,
  input  logic             b_valid,
  output logic             winner,
  output logic             winner_valid
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  // The owner may keep going below the burst limit, or past it when nobody else waits
  logic may_extend;
  assign may_extend = (cnt < MAX_CNT);

  // Owner continuation first, then round-robin tie-break, then the lone requester
  always_comb begin
    winner       = SEL_A;
    winner_valid = 1'b0;
    if (owner == OWN_A && a_valid && (may_extend || !b_valid)) begin
      winner       = SEL_A;
      winner_valid = 1'b1;
    end else if (owner == OWN_B && b_valid && (may_extend || !a_valid)) begin
      winner       = SEL_B;
      winner_valid = 1'b1;
    end else if (a_valid && b_valid) begin
      winner       = ~last_winner;
      winner_valid = 1'b1;
    end else if (a_valid) begin
      winner       = SEL_A;
      winner_valid = 1'b1;
    end else if (b_valid) begin
      winner       = SEL_B;
      winner_valid = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - two-port register-file write arbiter with one-entry output stage
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W    = WB_DATA_W,
  parameter int RD_W      = WB_RD_W,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_port_arbiter_if.slave    bus
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  owner_t            owner;
  logic [CNT_W-1:0]  cnt;
  logic              last_winner;
  logic              out_valid_q;
  logic              out_sel_q;
  logic [DATA_W-1:0] out_data_q;
  logic [RD_W-1:0]   out_rd_q;

  logic              load_ok;
  logic              winner;
  logic              winner_valid;
  logic              take;
  logic              same_owner;

  // Stage can accept when empty or being drained this cycle
  assign load_ok = !out_valid_q || bus.out_ready;

  // rst_n gates the readies so nothing is accepted while reset is held
  assign take        = rst_n && load_ok && winner_valid;
  assign bus.a_ready = take && (winner == SEL_A);
  assign bus.b_ready = take && (winner == SEL_B);

  assign same_owner = ((winner == SEL_A) && (owner == OWN_A)) ||
                      ((winner == SEL_B) && (owner == OWN_B));

  wbarb_pick #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_pick (
    .owner        (owner),
    .cnt          (cnt),
    .last_winner  (last_winner),
    .a_valid      (bus.a_valid),
    .b_valid      (bus.b_valid),
    .winner       (winner),
    .winner_valid (winner_valid)
  );

  // Ownership FSM, burst counter and registered write-back entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= IDLE;
      cnt         <= '0;
      last_winner <= SEL_B;
      out_valid_q <= 1'b0;
      out_sel_q   <= SEL_A;
      out_data_q  <= '0;
      out_rd_q    <= '0;
    end else if (load_ok) begin
      if (winner_valid) begin
        out_valid_q <= 1'b1;
        out_sel_q   <= winner;
        out_data_q  <= (winner == SEL_B) ? bus.b_data : bus.a_data;
        out_rd_q    <= (winner == SEL_B) ? bus.b_rd : bus.a_rd;
        last_winner <= winner;
        owner       <= (winner == SEL_B) ? OWN_B : OWN_A;
        if (same_owner) begin
          cnt <= (cnt == MAX_CNT) ? cnt : cnt + ONE_CNT;
        end else begin
          cnt <= ONE_CNT;
        end
      end else begin
        out_valid_q <= 1'b0;
        owner       <= IDLE;
        cnt         <= '0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_rd    = out_rd_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - randomized and directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(
    .DATA_W    (64),
    .RD_W      (5),
    .MAX_BURST (MAXB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: who holds the stream, how long the current streak is,
  // who won last, and what write is waiting at the register file.
  int          m_owner;   // 0 nobody, 1 A, 2 B
  int          m_streak;
  int          m_last;    // 1 A, 2 B
  bit          m_v;
  bit          m_sel;
  logic [63:0] m_data;
  logic [4:0]  m_rd;

  function automatic void model_reset();
    m_owner = 0; m_streak = 0; m_last = 2;
    m_v = 0; m_sel = 0; m_data = '0; m_rd = '0;
  endfunction

  function automatic int model_pick(bit av, bit bv);
    if (m_owner == 1 && av && (m_streak < MAXB || !bv)) return 1;
    if (m_owner == 2 && bv && (m_streak < MAXB || !av)) return 2;
    if (av && bv) return (m_last == 1) ? 2 : 1;
    if (av) return 1;
    if (bv) return 2;
    return 0;
  endfunction

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_owner();
    owner_t o;
    o = (m_owner == 1) ? OWN_A : (m_owner == 2) ? OWN_B : IDLE;
    return o;
  endfunction

  // One clock: drive at negedge, check readies, model the edge, check outputs
  task automatic cycle(input bit av, input bit bv,
                       input logic [63:0] ad, input logic [63:0] bd,
                       input logic [4:0] ar, input logic [4:0] br,
                       input bit ordy, output int granted);
    int  w;
    bit  lok;
    @(negedge clk);
    bus.a_valid = av; bus.b_valid = bv;
    bus.a_data = ad;  bus.b_data = bd;
    bus.a_rd = ar;    bus.b_rd = br;
    bus.out_ready = ordy;
    #1;
    lok = !m_v || ordy;
    w = lok ? model_pick(av, bv) : 0;
    expect_eq("a_ready", bus.a_ready, (w == 1));
    expect_eq("b_ready", bus.b_ready, (w == 2));
    granted = w;
    @(posedge clk);
    if (lok) begin
      if (w != 0) begin
        m_streak = (w == m_owner) ? ((m_streak < MAXB) ? m_streak + 1 : MAXB) : 1;
        m_owner = w; m_last = w; m_v = 1; m_sel = (w == 2);
        m_data = (w == 2) ? bd : ad;
        m_rd = (w == 2) ? br : ar;
      end else begin
        m_v = 0; m_owner = 0; m_streak = 0;
      end
    end
    #1;
    expect_eq("out_valid", bus.out_valid, m_v);
    expect_eq("out_sel", bus.out_sel, m_sel);
    expect_eq("out_data", bus.out_data, m_data);
    expect_eq("out_rd", bus.out_rd, m_rd);
    expect_eq("cnt", dut.cnt, m_streak);
    expect_eq("owner", dut.owner, exp_owner());
  endtask

  // Assert reset (asynchronously), confirm outputs cleared, release with idle inputs
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    expect_eq("rst_out_valid", bus.out_valid, 0);
    expect_eq("rst_out_data", bus.out_data, 0);
    expect_eq("rst_out_sel", bus.out_sel, 0);
    expect_eq("rst_out_rd", bus.out_rd, 0);
    expect_eq("rst_a_ready", bus.a_ready, 0);
    expect_eq("rst_b_ready", bus.b_ready, 0);
    expect_eq("rst_owner", dut.owner, IDLE);
    repeat (2) @(negedge clk);
    bus.a_valid = 0; bus.b_valid = 0; bus.out_ready = 0;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    int g;
    int seq [10];
    int pat [10];
    bit pa, pb;
    logic [63:0] pad, pbd;
    logic [4:0]  par, pbr;

    pat = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
    bus.a_valid = 1; bus.b_valid = 1;
    bus.a_data = 64'h1111; bus.b_data = 64'h2222;
    bus.a_rd = 5'd1; bus.b_rd = 5'd2;
    bus.out_ready = 1;
    model_reset();
    #2;
    do_reset();

    // Burst limit under continuous contention; A takes the first tie
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 64'hA000 + i, 64'hB000 + i, 5'd3, 5'd4, 1, g);
      seq[i] = g;
    end
    for (int i = 0; i < 10; i++) expect_eq($sformatf("burst_seq%0d", i), seq[i], pat[i]);

    // Reset mid-burst with an entry held
    do_reset();

    // Single port B
    cycle(0, 1, 64'h0, 64'hDEAD_BEEF_0000_0001, 5'd0, 5'd7, 1, g);
    expect_eq("single_b_grant", g, 2);
    expect_eq("single_b_data", bus.out_data, 64'hDEAD_BEEF_0000_0001);
    expect_eq("single_b_rd", bus.out_rd, 7);
    expect_eq("single_b_sel", bus.out_sel, 1);

    // Idle drain
    cycle(0, 0, 64'h0, 64'h0, 5'd0, 5'd0, 1, g);
    expect_eq("drain_valid", bus.out_valid, 0);
    expect_eq("drain_owner", dut.owner, IDLE);

    // Backpressure: hold entry, both valid, stall five cycles, then drain+reload
    cycle(1, 0, 64'h5555, 64'h0, 5'd9, 5'd0, 0, g);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 64'h6666, 64'h7777, 5'd10, 5'd11, 0, g);
      expect_eq("bp_no_grant", g, 0);
      expect_eq("bp_hold_data", bus.out_data, 64'h5555);
    end
    cycle(1, 1, 64'h6666, 64'h7777, 5'd10, 5'd11, 1, g);
    expect_eq("bp_reload_data", bus.out_data, 64'h6666);

    // Yield: A owns at streak 2, then A drops and B takes over with cnt 1
    do_reset();
    cycle(1, 0, 64'h10, 64'h0, 5'd1, 5'd0, 1, g);
    cycle(1, 0, 64'h11, 64'h0, 5'd1, 5'd0, 1, g);
    expect_eq("yield_cnt2", dut.cnt, 2);
    cycle(0, 1, 64'h0, 64'h20, 5'd0, 5'd2, 1, g);
    expect_eq("yield_grant_b", g, 2);
    expect_eq("yield_cnt1", dut.cnt, 1);

    // Randomized traffic with requesters that hold data until accepted
    pa = 0; pb = 0; pad = '0; pbd = '0; par = '0; pbr = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pa && ($urandom_range(0, 2) != 0)) begin
        pa = 1; pad = {$urandom, $urandom}; par = 5'($urandom);
      end
      if (!pb && ($urandom_range(0, 2) != 0)) begin
        pb = 1; pbd = {$urandom, $urandom}; pbr = 5'($urandom);
      end
      cycle(pa && ($urandom_range(0, 7) != 0), pb && ($urandom_range(0, 7) != 0),
            pad, pbd, par, pbr, ($urandom_range(0, 3) != 0), g);
      if (g == 1) pa = 0;
      if (g == 2) pb = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
